// File: rtl/nn_event_array.sv
// Event-driven synapse array: queued row spikes are walked one column per cycle into
// saturating dendrite accumulators, which are published and cleared on each tick.
//   state   | meaning
//   IDLE    | waiting for a queued spike or a pending tick
//   ACCUM   | adding W[row][col] into acc[col], one column per cycle
//   PUBLISH | current_out/current_valid presented, tick_pending cleared
module nn_event_array #(
    parameter int NUM_SYNAPSE_ROWS = 4,
    parameter int NUM_COLS         = 4,
    parameter int WEIGHT_W         = 8,
    parameter int CUR_W            = 16,
    parameter int FIFO_DEPTH       = 4,
    localparam int RW = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      spike_valid,
    input  logic [RW-1:0]             spike_row,
    output logic                      spike_ready,
    input  logic                      cfg_we,
    input  logic [RW-1:0]             cfg_row,
    input  logic [CW-1:0]             cfg_col,
    input  logic [WEIGHT_W-1:0]       cfg_weight,
    input  logic                      tick,
    output logic [NUM_COLS*CUR_W-1:0] current_out,
    output logic                      current_valid,
    output logic                      busy,
    output logic                      err_row
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [RW:0] ROW_LIM = (RW+1)'(NUM_SYNAPSE_ROWS);
    localparam logic [CW:0] COL_LIM = (CW+1)'(NUM_COLS);
    localparam logic signed [CUR_W-1:0] CUR_MAX = {1'b0, {(CUR_W-1){1'b1}}};
    localparam logic signed [CUR_W-1:0] CUR_MIN = {1'b1, {(CUR_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

    state_t                     state;
    logic signed [WEIGHT_W-1:0] weight [NUM_SYNAPSE_ROWS][NUM_COLS];
    logic signed [CUR_W-1:0]    acc [NUM_COLS];
    logic [RW-1:0]              fifo_mem [FIFO_DEPTH];
    logic [AW:0]                wr_ptr;
    logic [AW:0]                rd_ptr;
    logic [RW-1:0]              row;
    logic [CW-1:0]              col;
    logic                       tick_pending;

    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       push;
    logic                       pop;
    logic                       last_col;
    logic [RW-1:0]              head_row;
    logic                       head_bad;
    logic                       row_ok;
    logic                       cfg_ok;
    logic signed [WEIGHT_W-1:0] w_sel;
    logic signed [CUR_W:0]      sum;
    logic signed [CUR_W-1:0]    sum_sat;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign spike_ready = reset && !fifo_full && !tick_pending;
    assign push        = spike_valid && spike_ready;
    assign last_col    = (col == CW'(NUM_COLS - 1));
    assign pop         = !fifo_empty && ((state == IDLE) || ((state == ACCUM) && last_col));
    assign head_row    = fifo_mem[rd_ptr[AW-1:0]];
    assign head_bad    = !({1'b0, head_row} < ROW_LIM);
    assign row_ok      = ({1'b0, row} < ROW_LIM);
    assign cfg_ok      = ({1'b0, cfg_row} < ROW_LIM) && ({1'b0, cfg_col} < COL_LIM);
    assign busy        = (state != IDLE) || !fifo_empty || tick_pending;

    // An out-of-range row still walks all columns but contributes nothing.
    always_comb begin
        w_sel = '0;
        if (row_ok) begin
            w_sel = weight[row][col];
        end
    end

    always_comb begin
        sum     = {acc[col][CUR_W-1], acc[col]}
                + {{(CUR_W+1-WEIGHT_W){w_sel[WEIGHT_W-1]}}, w_sel};
        sum_sat = sum[CUR_W-1:0];
        if (sum[CUR_W] != sum[CUR_W-1]) begin
            sum_sat = sum[CUR_W] ? CUR_MIN : CUR_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= spike_row;
        end
    end

    // A write sampled on the same edge as an ACCUM read leaves that read with the old weight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    weight[r][c] <= '0;
                end
            end
        end else if (cfg_we && cfg_ok) begin
            weight[cfg_row][cfg_col] <= cfg_weight;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            row           <= '0;
            col           <= '0;
            tick_pending  <= 1'b0;
            current_out   <= '0;
            current_valid <= 1'b0;
            err_row       <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            current_valid <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                row    <= head_row;
                col    <= '0;
                if (head_bad) begin
                    err_row <= 1'b1;
                end
            end
            if (tick) begin
                tick_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= ACCUM;
                    end else if (tick_pending) begin
                        for (int c = 0; c < NUM_COLS; c++) begin
                            current_out[c*CUR_W +: CUR_W] <= acc[c];
                            acc[c] <= '0;
                        end
                        current_valid <= 1'b1;
                        state         <= PUBLISH;
                    end
                end
                ACCUM: begin
                    acc[col] <= sum_sat;
                    if (!last_col) begin
                        col <= col + CW'(1);
                    end else if (fifo_empty) begin
                        state <= IDLE;
                    end
                end
                PUBLISH: begin
                    tick_pending <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_event_array.sv
// Randomized + directed bench for nn_event_array against a queue-based behavioural model.
// Small parameters (3 rows, 10-bit currents) so range errors and saturation are reachable.
module tb_nn_event_array;

    localparam int N   = 3;
    localparam int C   = 4;
    localparam int WW  = 8;
    localparam int CUR = 10;
    localparam int FD  = 4;
    localparam int RW  = 2;
    localparam int CW  = 2;
    localparam int CMAX = 511;
    localparam int CMIN = -512;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              spike_valid = 1'b0;
    logic [RW-1:0]     spike_row = '0;
    logic              spike_ready;
    logic              cfg_we = 1'b0;
    logic [RW-1:0]     cfg_row = '0;
    logic [CW-1:0]     cfg_col = '0;
    logic [WW-1:0]     cfg_weight = '0;
    logic              tick = 1'b0;
    logic [C*CUR-1:0]  current_out;
    logic              current_valid;
    logic              busy;
    logic              err_row;

    nn_event_array #(
        .NUM_SYNAPSE_ROWS(N), .NUM_COLS(C), .WEIGHT_W(WW), .CUR_W(CUR), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset),
        .spike_valid(spike_valid), .spike_row(spike_row), .spike_ready(spike_ready),
        .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_weight(cfg_weight),
        .tick(tick), .current_out(current_out), .current_valid(current_valid),
        .busy(busy), .err_row(err_row)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_col(input int c);
        return int'($signed(current_out[c*CUR +: CUR]));
    endfunction

    function automatic int sat(input int v);
        if (v > CMAX) return CMAX;
        if (v < CMIN) return CMIN;
        return v;
    endfunction

    // Model: queue of pending rows, the spike in flight and which column it reaches next.
    int mq[$];
    int m_mode;      // 0 waiting, 1 walking a spike, 2 publish cycle
    int m_row;
    int m_col;
    bit m_tp;
    bit m_valid;
    bit m_err;
    bit m_rdy;
    int pre_mode;
    int wv;
    int m_acc[C];
    int m_cur[C];
    int m_w[N][C];

    function automatic void model_pop();
        m_row  = mq.pop_front();
        m_col  = 0;
        m_mode = 1;
        if (m_row >= N) m_err = 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_mode = 0; m_row = 0; m_col = 0;
            m_tp = 1'b0; m_valid = 1'b0; m_err = 1'b0;
            for (int c = 0; c < C; c++) begin
                m_acc[c] = 0;
                m_cur[c] = 0;
                for (int r = 0; r < N; r++) m_w[r][c] = 0;
            end
        end else begin
            m_rdy    = (mq.size() < FD) && !m_tp;
            pre_mode = m_mode;
            m_valid  = 1'b0;
            if (m_mode == 1) begin
                wv = (m_row < N) ? m_w[m_row][m_col] : 0;
                m_acc[m_col] = sat(m_acc[m_col] + wv);
                if (m_col == C - 1) begin
                    if (mq.size() > 0) model_pop();
                    else m_mode = 0;
                end else begin
                    m_col++;
                end
            end else if (m_mode == 0) begin
                if (mq.size() > 0) begin
                    model_pop();
                end else if (m_tp) begin
                    for (int c = 0; c < C; c++) begin
                        m_cur[c] = m_acc[c];
                        m_acc[c] = 0;
                    end
                    m_valid = 1'b1;
                    m_mode  = 2;
                end
            end else begin
                m_mode = 0;
            end
            if (spike_valid && m_rdy) mq.push_back(int'(spike_row));
            m_tp = (pre_mode == 2) ? 1'b0 : (m_tp || tick);
            if (cfg_we && int'(cfg_row) < N && int'(cfg_col) < C)
                m_w[cfg_row][cfg_col] = int'($signed(cfg_weight));
        end
    end

    always @(negedge clk) begin
        check("spike_ready", spike_ready, reset && (mq.size() < FD) && !m_tp);
        check("current_valid", current_valid, m_valid);
        check("busy", busy, (m_mode != 0) || (mq.size() != 0) || m_tp);
        check("err_row", err_row, m_err);
        for (int c = 0; c < C; c++) check("current_out_col", dut_col(c), m_cur[c]);
    end

    int pub[C];
    int pulses;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg(input int r, input int c, input int w);
        cfg_we = 1'b1; cfg_row = RW'(r); cfg_col = CW'(c); cfg_weight = w[WW-1:0];
        step();
        cfg_we = 1'b0;
    endtask

    // Leaves spike_valid high after acceptance so the caller can chain back-to-back spikes.
    task automatic send(input int r);
        spike_valid = 1'b1;
        spike_row   = RW'(r);
        for (int i = 0; i < 100; i++) begin
            if (spike_ready) begin
                step();
                return;
            end
            step();
        end
        errors++;
        $display("FAIL send_timeout: spike row %0d never accepted", r);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            step();
        end
        errors++;
        $display("FAIL idle_timeout: busy still 1, required 0");
    endtask

    task automatic watch_publish(input int cycles);
        bit took;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (current_valid) begin
                pulses++;
                for (int c = 0; c < C; c++) pub[c] = dut_col(c);
            end
            took = spike_valid && spike_ready;
            step();
            if (took) spike_valid = 1'b0;
        end
    endtask

    task automatic do_publish();
        tick = 1'b1;
        step();
        tick = 1'b0;
        watch_publish(60);
    endtask

    initial begin
        step(); step();
        check("rst_ready", spike_ready, 0);
        check("rst_current", current_out, 0);
        reset = 1'b1;
        step();

        // weights 1..4 on row 1, one spike, then an empty step
        for (int c = 0; c < C; c++) cfg(1, c, c + 1);
        send(1); spike_valid = 1'b0;
        do_publish();
        check("t1_pulses", pulses, 1);
        check("t1_col0", pub[0], 1); check("t1_col1", pub[1], 2);
        check("t1_col2", pub[2], 3); check("t1_col3", pub[3], 4);
        do_publish();
        check("t1_zero_pulses", pulses, 1);
        check("t1_zero_col0", pub[0], 0); check("t1_zero_col3", pub[3], 0);

        // FIFO fill behind a busy spike
        for (int c = 0; c < C; c++) cfg(0, c, -2);
        wait_idle();
        send(1);
        for (int k = 0; k < 4; k++) send(0);
        spike_row = 0;
        check("t2_full_ready", spike_ready, 0);
        step();
        spike_valid = 1'b0;
        do_publish();
        check("t2_col0", pub[0], -7); check("t2_col1", pub[1], -6);
        check("t2_col2", pub[2], -5); check("t2_col3", pub[3], -4);

        // saturation both ways
        cfg(2, 0, 127);
        for (int k = 0; k < 5; k++) send(2);
        spike_valid = 1'b0;
        do_publish();
        check("t3_pos_sat", pub[0], 511); check("t3_pos_col1", pub[1], 0);
        cfg(2, 0, -128);
        for (int k = 0; k < 5; k++) send(2);
        spike_valid = 1'b0;
        do_publish();
        check("t3_neg_sat", pub[0], -512);

        // tick with spikes queued, a merged second tick and a stalled spike
        wait_idle();
        send(1);
        for (int k = 0; k < 3; k++) send(0);
        spike_valid = 1'b0;
        tick = 1'b1; step(); tick = 1'b0; step();
        tick = 1'b1; spike_valid = 1'b1; spike_row = 1;
        check("t4_stalled_ready", spike_ready, 0);
        step();
        tick = 1'b0;
        watch_publish(60);
        check("t4_pulses", pulses, 1);
        check("t4_col0", pub[0], -5); check("t4_col1", pub[1], -4);
        check("t4_col2", pub[2], -3); check("t4_col3", pub[3], -2);
        wait_idle();
        do_publish();
        check("t4_next_col0", pub[0], 1); check("t4_next_col3", pub[3], 4);

        // out-of-range row, then reset in the middle of ACCUM
        send(3); spike_valid = 1'b0;
        wait_idle();
        check("t5_err", err_row, 1);
        do_publish();
        check("t5_col0", pub[0], 0); check("t5_col2", pub[2], 0);
        send(1); spike_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        check("t5_rst_current", current_out, 0);
        check("t5_rst_valid", current_valid, 0);
        check("t5_rst_err", err_row, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", spike_ready, 0);
        step();
        reset = 1'b1;
        step();

        // config write colliding with the ACCUM read of W[1][2]
        cfg(1, 0, 1); cfg(1, 1, 2); cfg(1, 2, 5); cfg(1, 3, 4);
        wait_idle();
        send(1); spike_valid = 1'b0;
        step(); step(); step();
        cfg(1, 2, 9);
        send(1); spike_valid = 1'b0;
        do_publish();
        check("t6_col0", pub[0], 2); check("t6_col1", pub[1], 4);
        check("t6_col2", pub[2], 14); check("t6_col3", pub[3], 8);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            spike_valid = ($urandom_range(0, 99) < 40);
            spike_row   = RW'($urandom_range(0, 3));
            cfg_we      = ($urandom_range(0, 99) < 10);
            cfg_row     = RW'($urandom_range(0, 3));
            cfg_col     = CW'($urandom_range(0, 3));
            cfg_weight  = WW'($urandom);
            tick        = ($urandom_range(0, 99) < 5);
            reset       = ($urandom_range(0, 999) >= 3);
            step();
        end
        spike_valid = 1'b0; cfg_we = 1'b0; tick = 1'b0; reset = 1'b1;
        step();
        wait_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
